// File: rtl/addsub_rr_arbiter.sv
// addsub_rr_arbiter: round-robin front end that shares one N-bit add/sub
// datapath between two requesters and returns a tagged, registered result
// over a valid/ready handshake.

// Ripple-carry add/sub unit. Operands are zero-extended to N+1 bits;
// subtraction inverts B and injects k as carry-in, giving (A-B) mod 2^(N+1).
module addsub_unit #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         k,
  output logic [N:0]   s
);

  logic [N:0] a_ext;
  logic [N:0] b_ext;
  logic [N:0] b_x;
  logic [N:0] carry;

  assign a_ext    = {1'b0, a};
  assign b_ext    = {1'b0, b};
  assign carry[0] = k;

  genvar gi;
  generate
    for (gi = 0; gi <= N; gi++) begin : g_bit
      // B is conditionally inverted so the same adder handles add and subtract
      assign b_x[gi] = b_ext[gi] ^ k;
      assign s[gi]   = a_ext[gi] ^ b_x[gi] ^ carry[gi];
      // The carry out of the top bit is discarded (result is modulo 2^(N+1))
      if (gi < N) begin : g_carry
        assign carry[gi+1] = (a_ext[gi] & b_x[gi]) |
                             (carry[gi] & (a_ext[gi] ^ b_x[gi]));
      end
    end
  endgenerate

endmodule

module addsub_rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req0_k,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic         req1_k,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N:0]   res_s,
  output logic         res_id,
  output logic         res_k
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t       state_reg;
  logic [N-1:0] op_a_reg;
  logic [N-1:0] op_b_reg;
  logic         op_k_reg;
  logic         op_id_reg;
  logic         last_grant_reg;

  logic         grant;
  logic         accept;
  logic [N-1:0] sel_a;
  logic [N-1:0] sel_b;
  logic         sel_k;
  logic [N:0]   sum;

  // Grant selection: a lone requester wins; on contention the requester
  // that did not win last time gets the slot.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_reg;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  // Ready only in IDLE, so requests seen during EXEC/RESP are left pending
  assign req0_ready = (state_reg == IDLE) & req0_valid & ~grant;
  assign req1_ready = (state_reg == IDLE) & req1_valid &  grant;
  assign accept     = req0_ready | req1_ready;

  assign sel_a = grant ? req1_a : req0_a;
  assign sel_b = grant ? req1_b : req0_b;
  assign sel_k = grant ? req1_k : req0_k;

  // Shared datapath, fed only from the captured operand registers
  addsub_unit #(
    .N (N)
  ) u_addsub (
    .a (op_a_reg),
    .b (op_b_reg),
    .k (op_k_reg),
    .s (sum)
  );

  // Control FSM: capture operands, register the sum, hold the result until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      op_a_reg       <= '0;
      op_b_reg       <= '0;
      op_k_reg       <= 1'b0;
      op_id_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      res_valid      <= 1'b0;
      res_s          <= '0;
      res_id         <= 1'b0;
      res_k          <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            op_a_reg       <= sel_a;
            op_b_reg       <= sel_b;
            op_k_reg       <= sel_k;
            op_id_reg      <= grant;
            last_grant_reg <= grant;
            state_reg      <= EXEC;
          end
        end
        EXEC: begin
          res_s     <= sum;
          res_id    <= op_id_reg;
          res_k     <= op_k_reg;
          res_valid <= 1'b1;
          state_reg <= RESP;
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          res_valid <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// Testbench for addsub_rr_arbiter: vector table plus hand-written sequences
// for contention, back-pressure and reset, with a result scoreboard.
module tb_addsub_rr_arbiter;

  localparam int N = 4;

  logic         clk;
  logic         rst_n;
  logic         req0_valid;
  logic         req0_ready;
  logic [N-1:0] req0_a;
  logic [N-1:0] req0_b;
  logic         req0_k;
  logic         req1_valid;
  logic         req1_ready;
  logic [N-1:0] req1_a;
  logic [N-1:0] req1_b;
  logic         req1_k;
  logic         res_valid;
  logic         res_ready;
  logic [N:0]   res_s;
  logic         res_id;
  logic         res_k;

  typedef struct {
    logic       id;
    logic [3:0] a;
    logic [3:0] b;
    logic       k;
    logic [4:0] s;
  } vec_t;

  typedef struct packed {
    logic [4:0] s;
    logic       id;
    logic       k;
  } exp_t;

  vec_t vecs [8];
  exp_t exp_q [$];
  int   tests;
  int   fails;

  addsub_rr_arbiter #(
    .N (N)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_k     (req0_k),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_k     (req1_k),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_s      (res_s),
    .res_id     (res_id),
    .res_k      (res_k)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every result handshake is matched against the oldest expectation
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("[TB] result id=%0d k=%0d s=%0d (expected id=%0d k=%0d s=%0d)",
                 res_id, res_k, res_s, e.id, e.k, e.s);
        check("res_s", res_s, e.s);
        check("res_id", res_id, e.id);
        check("res_k", res_k, e.k);
      end
    end
  end

  task automatic clear_reqs();
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_k = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_k = 1'b0;
  endtask

  task automatic drive_req(input logic id, input logic [3:0] a, input logic [3:0] b, input logic k);
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_k = k;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_k = k;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    clear_reqs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Present one request alone, wait for its accept, optionally check latency
  task automatic issue(input logic id, input logic [3:0] a, input logic [3:0] b,
                       input logic k, input logic [4:0] exp_s,
                       input bit push, input bit chk_lat);
    bit   got;
    exp_t e;
    got = 1'b0;
    @(posedge clk);
    #1 drive_req(id, a, b, k);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if ((id ? req1_ready : req0_ready) === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      check("accept_timeout", 0, 1);
      @(posedge clk);
      #1 clear_reqs();
    end else begin
      $display("[TB] accept id=%0d a=%0d b=%0d k=%0d", id, a, b, k);
      check("other_ready_low", id ? req0_ready : req1_ready, 0);
      if (push) begin
        e.s = exp_s; e.id = id; e.k = k;
        exp_q.push_back(e);
      end
      @(posedge clk);
      #1 clear_reqs();
      if (chk_lat) begin
        @(negedge clk);
        check("lat_exec_no_valid", res_valid, 0);
        @(negedge clk);
        check("lat_resp_valid", res_valid, 1);
      end
    end
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) @(negedge clk);
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  task automatic wait_res_valid();
    bool_loop: for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (res_valid === 1'b1) break;
    end
    check("res_valid_seen", res_valid, 1);
  endtask

  initial begin
    int   n;
    int   last_cyc;
    exp_t e;

    tests = 0;
    fails = 0;
    vecs[0] = '{id: 1'b0, a: 4'd9,  b: 4'd5,  k: 1'b0, s: 5'd14};
    vecs[1] = '{id: 1'b1, a: 4'd3,  b: 4'd7,  k: 1'b1, s: 5'd28};
    vecs[2] = '{id: 1'b1, a: 4'd15, b: 4'd15, k: 1'b0, s: 5'd30};
    vecs[3] = '{id: 1'b0, a: 4'd0,  b: 4'd0,  k: 1'b1, s: 5'd0};
    vecs[4] = '{id: 1'b0, a: 4'd0,  b: 4'd1,  k: 1'b1, s: 5'd31};
    vecs[5] = '{id: 1'b1, a: 4'd8,  b: 4'd3,  k: 1'b1, s: 5'd5};
    vecs[6] = '{id: 1'b0, a: 4'd7,  b: 4'd12, k: 1'b1, s: 5'd27};
    vecs[7] = '{id: 1'b1, a: 4'd12, b: 4'd10, k: 1'b0, s: 5'd22};

    rst_n     = 1'b0;
    res_ready = 1'b1;
    clear_reqs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_s", res_s, 0);
    check("rst_res_id", res_id, 0);
    check("rst_res_k", res_k, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Table-driven single operations with latency checks
    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].k, vecs[i].s, 1'b1, 1'b1);
      wait_drain();
    end

    // Continuous contention: grants alternate starting with requester 0
    do_reset();
    @(posedge clk);
    #1;
    drive_req(1'b0, 4'd5, 4'd2, 1'b1);
    drive_req(1'b1, 4'd6, 4'd9, 1'b0);
    n = 0;
    last_cyc = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        $display("[TB] contention accept #%0d id=%0d", n, req1_ready);
        check("cont_grant_order", req1_ready, n % 2);
        check("cont_single_ready", req0_ready & req1_ready, 0);
        if (n > 0) check("cont_spacing", cyc - last_cyc, 3);
        e.id = req1_ready;
        e.k  = req1_ready ? 1'b0 : 1'b1;
        e.s  = req1_ready ? 5'd15 : 5'd3;
        exp_q.push_back(e);
        last_cyc = cyc;
        n++;
        if (n == 4) break;
      end
    end
    check("cont_accepts", n, 4);
    @(posedge clk);
    #1 clear_reqs();
    wait_drain();

    // Back-pressure: result held stable, no accepts, then grant flips
    res_ready = 1'b0;
    issue(1'b0, 4'd2, 4'd3, 1'b0, 5'd5, 1'b1, 1'b0);
    drive_req(1'b0, 4'd1, 4'd1, 1'b0);
    drive_req(1'b1, 4'd10, 4'd4, 1'b1);
    wait_res_valid();
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", res_valid, 1);
      check("stall_s", res_s, 5);
      check("stall_id", res_id, 0);
      check("stall_no_ready", req0_ready | req1_ready, 0);
      if (i < 4) @(negedge clk);
    end
    @(posedge clk);
    #1 res_ready = 1'b1;
    @(negedge clk);
    check("handshake_no_ready", req0_ready | req1_ready, 0);
    @(negedge clk);
    check("after_stall_req1_ready", req1_ready, 1);
    check("after_stall_req0_ready", req0_ready, 0);
    e.s = 5'd6; e.id = 1'b1; e.k = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1 clear_reqs();
    wait_drain();

    // Reset during EXEC: nothing is delivered
    do_reset();
    issue(1'b0, 4'd4, 4'd4, 1'b0, 5'd8, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_exec_valid", res_valid, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_exec_no_pulse", res_valid, 0);
    end

    // Reset during RESP: pending result dropped, first contention goes to 0
    res_ready = 1'b0;
    issue(1'b0, 4'd9, 4'd1, 1'b0, 5'd10, 1'b0, 1'b0);
    wait_res_valid();
    check("resp_s_before_rst", res_s, 10);
    rst_n = 1'b0;
    #1;
    check("rst_resp_valid", res_valid, 0);
    check("rst_resp_s", res_s, 0);
    check("rst_resp_id", res_id, 0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    res_ready = 1'b1;
    drive_req(1'b0, 4'd6, 4'd3, 1'b1);
    drive_req(1'b1, 4'd2, 4'd2, 1'b0);
    @(negedge clk);
    check("post_rst_req0_ready", req0_ready, 1);
    check("post_rst_req1_ready", req1_ready, 0);
    e.s = 5'd3; e.id = 1'b0; e.k = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1 clear_reqs();
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
